// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: prioritised next-pc selection (reset, trap,
// trap return, stall, redirect, RAS pop, sequential) with a circular return-address stack.
module pc_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              RAS_DEPTH = 4,
  parameter int              C_EXT     = 1
) (
  input  logic            i_clk,
  input  logic            i_clr_n,
  input  logic            i_stall,
  input  logic            i_step_half,
  input  logic            i_redirect_en,
  input  logic [XLEN-1:0] i_redirect_target,
  input  logic            i_call,
  input  logic            i_ret,
  input  logic            i_trap,
  input  logic            i_trap_ret,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus,
  output logic [XLEN-1:0] o_epc,
  output logic            o_ras_empty,
  output logic            o_ras_full,
  output logic            o_ret_miss,
  output logic            o_target_misaligned
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   RAS_MAX    = CW'(RAS_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [CW-1:0]   r_cnt;
  logic            r_ret_miss;
  logic            r_misaligned;

  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_pc_plus;
  logic [XLEN-1:0] w_tgt;
  logic            w_tgt_bad;
  logic [PW-1:0]   w_top_idx;
  logic [XLEN-1:0] w_top;
  logic            w_flow;
  logic            w_take_redir;
  logic            w_take_ret;
  logic            w_push;
  logic            w_pop;
  logic            w_miss;
  logic            w_empty;
  logic [XLEN-1:0] w_pc_nxt;

  assign w_step    = (C_EXT != 0 && i_step_half) ? XLEN'(2) : XLEN'(4);
  assign w_pc_plus = r_pc + w_step;

  assign w_tgt     = i_redirect_target & ~ALIGN_MASK;
  assign w_tgt_bad = |(i_redirect_target & ALIGN_MASK);

  // write pointer always points at the next free slot; top of stack sits just below it
  assign w_top_idx = r_wptr - 1'b1;
  assign w_top     = r_ras[w_top_idx];
  assign w_empty   = (r_cnt == '0);

  assign w_flow       = !i_trap && !i_trap_ret && !i_stall;
  assign w_take_redir = w_flow && i_redirect_en;
  assign w_take_ret   = w_flow && !i_redirect_en && i_ret;
  assign w_push       = w_take_redir && i_call;
  assign w_pop        = w_take_ret && !w_empty;
  assign w_miss       = w_take_ret && w_empty;

  always_comb begin
    w_pc_nxt = w_pc_plus;
    if (i_trap)            w_pc_nxt = TRAP_VEC;
    else if (i_trap_ret)   w_pc_nxt = r_epc;
    else if (i_stall)      w_pc_nxt = r_pc;
    else if (i_redirect_en) w_pc_nxt = w_tgt;
    else if (w_pop)        w_pc_nxt = w_top;
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_pc         <= RESET_VEC;
      r_epc        <= '0;
      r_wptr       <= '0;
      r_cnt        <= '0;
      r_ret_miss   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_ret_miss   <= w_miss;
      r_misaligned <= w_take_redir && w_tgt_bad;
      if (i_trap) r_epc <= r_pc;
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        // a full stack overwrites its oldest entry, so the count saturates
        if (r_cnt != RAS_MAX) r_cnt <= r_cnt + 1'b1;
      end else if (w_pop) begin
        r_wptr <= w_top_idx;
        r_cnt  <= r_cnt - 1'b1;
      end
    end
  end

  // stack contents carry no reset meaning; only the pointer and count are cleared
  always_ff @(posedge i_clk) begin
    if (i_clr_n && w_push) r_ras[r_wptr] <= w_pc_plus;
  end

  assign o_pc                = r_pc;
  assign o_pc_plus           = w_pc_plus;
  assign o_epc               = r_epc;
  assign o_ras_empty         = w_empty;
  assign o_ras_full          = (r_cnt == RAS_MAX);
  assign o_ret_miss          = r_ret_miss;
  assign o_target_misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plan plus random traffic against a queue-based reference model of the pc unit.
module tb_pc_sequencer;

  localparam int             DEPTH = 4;
  localparam logic [31:0]    RVEC  = 32'h0000_0000;
  localparam logic [31:0]    TVEC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        clr_n, stall, step_half, redirect_en, call, ret, trap, trap_ret;
  logic [31:0] redirect_target;
  logic [31:0] pc, pc_plus, epc;
  logic        ras_empty, ras_full, ret_miss, target_misaligned;

  int n_chk = 0;
  int n_fail = 0;

  // reference state
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];
  logic        m_miss, m_mis;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RESET_VEC(RVEC), .TRAP_VEC(TVEC), .RAS_DEPTH(DEPTH), .C_EXT(1)) dut (
    .i_clk(clk), .i_clr_n(clr_n), .i_stall(stall), .i_step_half(step_half),
    .i_redirect_en(redirect_en), .i_redirect_target(redirect_target),
    .i_call(call), .i_ret(ret), .i_trap(trap), .i_trap_ret(trap_ret),
    .o_pc(pc), .o_pc_plus(pc_plus), .o_epc(epc), .o_ras_empty(ras_empty),
    .o_ras_full(ras_full), .o_ret_miss(ret_miss), .o_target_misaligned(target_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic c, input logic st, input logic hf, input logic re,
                     input logic [31:0] tg, input logic ca, input logic rt,
                     input logic tp, input logic tr);
    logic [31:0] pp;
    clr_n = c; stall = st; step_half = hf; redirect_en = re; redirect_target = tg;
    call = ca; ret = rt; trap = tp; trap_ret = tr;
    #1;
    pp = m_pc + (hf ? 32'd2 : 32'd4);
    if (c) chk("pc_plus", pc_plus, pp);
    if (!c) begin
      m_pc = RVEC; m_epc = 0; m_ras.delete(); m_miss = 0; m_mis = 0;
    end else begin
      m_miss = 0; m_mis = 0;
      if (tp) begin
        m_epc = m_pc; m_pc = TVEC;
      end else if (tr) begin
        m_pc = m_epc;
      end else if (st) begin
        // hold
      end else if (re) begin
        m_mis = tg[0];
        if (ca) begin
          m_ras.push_back(pp);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        m_pc = {tg[31:1], 1'b0};
      end else if (rt) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = pp; m_miss = 1; end
      end else m_pc = pp;
    end
    @(posedge clk); #1;
    chk("pc", pc, m_pc);
    chk("epc", epc, m_epc);
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
    chk("ret_miss", 32'(ret_miss), 32'(m_miss));
    chk("target_misaligned", 32'(target_misaligned), 32'(m_mis));
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp(input logic [31:0] t, input logic ca);
    cyc(1, 0, 0, 1, t, ca, 0, 0, 0);
  endtask

  task automatic rret();
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    m_pc = 0; m_epc = 0; m_miss = 0; m_mis = 0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_empty", 32'(ras_empty), 32'd1);
    seq(4);
    chk("seq4_pc", pc, 32'h10);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("midreset_pc", pc, 32'h0);

    seq(2);
    jmp(32'h40, 1);
    chk("call_pc", pc, 32'h40);
    seq(2);
    rret();
    chk("ret_pc", pc, 32'hC);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) jmp(32'(k) << 8, 1);
    chk("nest_full", 32'(ras_full), 32'd1);
    rret(); chk("nest_r1", pc, 32'h404);
    rret(); chk("nest_r2", pc, 32'h304);
    rret(); chk("nest_r3", pc, 32'h204);
    rret(); chk("nest_r4", pc, 32'h104);
    rret(); chk("nest_r5", pc, 32'h108);
    chk("nest_miss", 32'(ret_miss), 32'd1);

    jmp(32'h20, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("trap_pc", pc, 32'h100);
    chk("trap_epc", epc, 32'h20);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("tret_pc", pc, 32'h20);

    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 32'h80, 0, 0, 0, 0);
    chk("stall_pc", pc, 32'h20);
    jmp(32'h10, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("half_pc", pc, 32'h12);
    jmp(32'h33, 0);
    chk("mis_pc", pc, 32'h32);
    chk("mis_flag", 32'(target_misaligned), 32'd1);
    seq(1);
    chk("mis_clear", 32'(target_misaligned), 32'd0);
    jmp(32'hFFFF_FFFC, 0);
    seq(1);
    chk("wrap_pc", pc, 32'h0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] tg;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: tg = $urandom;
        1: tg = $urandom & 32'hFFFF_FFFC;
        2: tg = 32'hFFFF_FFFC;
        default: tg = $urandom_range(0, 255);
      endcase
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 6) == 0, 1'($urandom),
          $urandom_range(0, 3) == 0, tg, 1'($urandom), $urandom_range(0, 4) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the RISC-V core fetch stage. It generates the fetch address every cycle from a prioritised set of sources: reset vector, trap vector, trap return, branch/jump redirect, return-address-stack pop, or sequential step. It supports stalls, 2- and 4-byte steps for the C extension, and a small circular return-address stack (RAS). It sits between the branch unit / CSR logic and instruction memory, and replaces the simple clear/load counter.

Parameters:
XLEN, 32, address width of pc and all target/vector ports
RESET_VEC, 32'h0000_0000, pc value after reset
TRAP_VEC, 32'h0000_0100, pc value loaded on trap
RAS_DEPTH, 4, return-address-stack entries (power of two, >=2)
C_EXT, 1, 1 = 2-byte steps and 2-byte-aligned targets allowed; 0 = 4-byte only

Ports:
clk  in  1  system clock, all state updates on rising edge
clr_n  in  1  synchronous active-low reset
stall  in  1  hold pc (ignored by trap/trap_ret)
step_half  in  1  current instruction is compressed: step +2 (ignored when C_EXT=0)
redirect_en  in  1  take redirect_target next cycle
redirect_target  in  XLEN  branch/jump target
call  in  1  with redirect_en: push return address to RAS
ret  in  1  pop RAS and jump to popped address
trap  in  1  take trap: save epc, jump to TRAP_VEC
trap_ret  in  1  return from trap: pc <= epc
pc  out  XLEN  current fetch address (registered)
pc_plus  out  XLEN  combinational pc + step (4, or 2 if C_EXT && step_half)
epc  out  XLEN  saved exception pc (registered)
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS count == RAS_DEPTH
ret_miss  out  1  registered 1-cycle pulse: ret taken with RAS empty
target_misaligned  out  1  registered 1-cycle pulse: redirect_target had illegal low bits

Behaviour:
- Synchronous reset. With clr_n=0 at a clock edge: pc=RESET_VEC, epc=0, RAS count=0, ras_empty=1, ras_full=0, ret_miss=0, target_misaligned=0. RAS entry contents do not matter.
- Next-pc priority per edge, highest first: reset > trap > trap_ret > stall > redirect_en > ret > sequential.
- trap: epc<=pc, pc<=TRAP_VEC. Takes effect even with stall=1. RAS is untouched.
- trap_ret: pc<=epc. epc is unchanged.
- stall=1 (no trap/trap_ret): pc, epc and RAS hold. ret_miss and target_misaligned go to 0.
- redirect_en: pc<=redirect_target with bit0 forced 0. When C_EXT=0, bit1 is also forced 0.
  - If any forced bit was 1, target_misaligned=1 for the next cycle.
  - If call=1, pc_plus is pushed onto the RAS in the same edge.
  - A ret asserted together with redirect_en is ignored; no pop occurs.
- call without redirect_en is ignored.
- ret (no redirect):
  - RAS non-empty: pc<=top entry, count decrements.
  - RAS empty: pc<=pc_plus, ret_miss=1 for one cycle.
- Sequential step: pc<=pc_plus. Arithmetic is modulo 2^XLEN, so pc=FFFF_FFFC +4 wraps to 0.
- RAS push when full: the oldest entry is overwritten (circular pointer), count stays RAS_DEPTH, ras_full stays 1.
- Pop after an overflow returns entries newest-first. Only the RAS_DEPTH most recent entries are recoverable.
- trap and trap_ret together: trap wins.
- ras_empty and ras_full are derived from the registered count. Latency for all redirects is 1 cycle: the new pc is visible the cycle after the request edge.

Test Plan:
- Reset, then 4 free cycles with step_half=0: pc = 0,4,8,C,10. Assert clr_n=0 for one edge mid-run: pc=0 next cycle, ras_empty=1.
- pc=8, redirect_en=1, target=0x40, call=1: pc=0x40 and the RAS holds 0xC. Two steps to 0x48, then ret=1: pc=0xC, ras_empty=1.
- Five nested calls with RAS_DEPTH=4 at pc=0x0,0x100,0x200,0x300,0x400 (returns 4,0x104,0x204,0x304,0x404), then five rets: pc=0x404,0x304,0x204,0x104, then pc_plus with ret_miss=1.
- pc=0x20, stall=1, trap=1: pc=0x100, epc=0x20. Then trap_ret: pc=0x20.
- stall=1 with redirect_en=1 for 3 cycles: pc holds. C_EXT=1 with step_half=1: 0x10 -> 0x12. Redirect target 0x33: pc=0x32, target_misaligned pulses once.
- Load pc=FFFF_FFFC via redirect, one step: pc=0000_0000.
